decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Instruction decode stage; consumer end of the fetch interface.
- Takes the fetched instruction and PC, reads a 32x32 register file, and resolves branches and jumps.
- Drives the fetch-side controls: target select, 7-bit target and fetch enable.
- Detects load-use and branch-operand hazards and emits the ID/EX pipeline register towards execute.

Parameters:
FLUSH_SLOTS, 1, number of already-fetched wrong-path instructions squashed after a taken branch or jump
PC_W, 7, PC width

Ports:
clk  in  1  clock
rst  in  1  reset
if_instr  in  32  fetched instruction word
if_pc  in  PC_W  PC+1 of if_instr
if_valid  in  1  if_instr/if_pc valid this cycle
fetch_sel  out  1  1 = fetch loads fetch_target (drives fetch mux select)
fetch_target  out  PC_W  branch/jump target
fetch_en  out  1  fetch PC update enable; 0 = hold
wb_we  in  1  writeback enable
wb_addr  in  5  writeback register
wb_data  in  32  writeback data
mem_rd  in  5  destination register of instruction in MEM
mem_we  in  1  MEM instruction writes a register
ex_valid  out  1  ID/EX entry valid
ex_ctrl  out  4  decoded op: 0 NOP, 1 ALU-R, 2 ADDI, 3 LW, 4 SW
ex_funct  out  6  R-type funct
ex_a  out  32  rs value
ex_b  out  32  rt value
ex_imm  out  32  sign-extended imm[15:0]
ex_rd  out  5  destination (rd for R-type, rt for ADDI/LW, 0 otherwise)
ex_pc  out  PC_W  PC+1 of instruction

Behaviour:
- Reset: rst synchronous, active-high; clock clk, rising edge.
  - All ex_* registers 0; FSM to RUN; flush counter 0; register file contents cleared.
  - fetch_sel 0 and fetch_en 1 while rst is high.
- Instruction format:
  - op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0], jtarget[6:0].
  - Opcodes: 000000 ALU-R; 001000 ADDI; 100011 LW; 101011 SW; 000100 BEQ; 000101 BNE; 000010 J.
  - Any other opcode decodes as NOP.
- Register file:
  - 32x32, r0 reads 0, writes to r0 ignored.
  - Write on posedge when wb_we.
  - Same-cycle read of wb_addr returns wb_data (write-through bypass), except r0.
- Load-use hazard: ID/EX holds valid LW with ex_rd != 0 and ex_rd equal to the current rs or rt. Then:
  - fetch_en = 0 and fetch_sel = 0.
  - Decode holds if_instr internally.
  - A bubble (ex_valid 0, ex_ctrl 0) enters ID/EX.
- Branch hazard: BEQ/BNE with rs or rt (nonzero) matching a valid ID/EX ex_rd, or matching mem_rd with mem_we. Stall as above until clear.
- Stall source and hold: all stalls are combinational on current state. The instruction in decode is captured in a skid register so if_instr may change during the stall.
- Branch/jump resolution (same cycle, when not stalled):
  - BEQ taken iff rs value == rt value; BNE taken iff unequal.
  - Taken target = (if_pc + imm[6:0]) mod 2^PC_W.
  - J target = jtarget.
  - When taken: fetch_sel = 1, fetch_target valid, fetch_en = 1 for exactly one cycle.
  - Branches and jumps enter ID/EX as NOP.
- FSM:
  - RUN → FLUSH on a taken branch/jump; counter loaded with FLUSH_SLOTS.
  - FLUSH: each if_valid input is discarded (bubble to ID/EX, no hazard check, no branch); counter decrements.
  - FLUSH → RUN when counter reaches 0.
  - if_valid low does not decrement the counter.
- if_valid low in RUN: bubble into ID/EX, no fetch_sel.
- Simultaneous events:
  - Stall has priority over branch resolution.
  - rst mid-stall or mid-FLUSH returns to RUN and drops the held instruction.
- Latency: decode-to-ID/EX is 1 cycle; branch redirect is 0 cycles combinational from the decoded word.

Optional Feature:
- Macro: DECODE_PERF_EN.
- Defined: adds outputs perf_stall[15:0] and perf_flush[15:0].
  - perf_stall counts stall cycles; perf_flush counts discarded instructions.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then ADDI r1,r0,5 (if_pc 1) → next cycle ex_valid 1, ex_ctrl 2, ex_a 0, ex_imm 5, ex_rd 1, ex_pc 1.
- wb_we=1, wb_addr=3, wb_data=32'hDEAD_BEEF in the same cycle ALU-R reads rs=3 → ex_a 32'hDEAD_BEEF. Also wb_addr=0 → r0 still reads 0.
- LW r2 in ID/EX, then ADD r4,r2,r1 → one cycle fetch_en 0 and bubble, then ADD issues with ex_ctrl 1.
- r5=r6=7, BEQ r5,r6,imm=3 at if_pc 10 → fetch_sel 1, fetch_target 13 for one cycle. Next valid instruction squashed (ex_valid 0); the following one issues.
- BNE with equal operands → no redirect, NOP to ID/EX. J jtarget=127 → fetch_target 127. BEQ at if_pc 126 imm=5 → target 3 (wrap).
- With DECODE_PERF_EN: two load-use stalls plus one taken branch → perf_stall 2, perf_flush 1. Assert rst → both 0.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction decode stage: register file, hazard stalls, branch/jump redirect and ID/EX register.
// Optional DECODE_PERF_EN adds saturating stall/flush counters (perf_stall, perf_flush).
module decode_stage #(
   parameter int unsigned FLUSH_SLOTS = 1,
   parameter int unsigned PC_W        = 7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     if_instr,
   input  logic [PC_W-1:0] if_pc,
   input  logic            if_valid,
   output logic            fetch_sel,
   output logic [PC_W-1:0] fetch_target,
   output logic            fetch_en,
   input  logic            wb_we,
   input  logic [4:0]      wb_addr,
   input  logic [31:0]     wb_data,
   input  logic [4:0]      mem_rd,
   input  logic            mem_we,
   output logic            ex_valid,
   output logic [3:0]      ex_ctrl,
   output logic [5:0]      ex_funct,
   output logic [31:0]     ex_a,
   output logic [31:0]     ex_b,
   output logic [31:0]     ex_imm,
   output logic [4:0]      ex_rd,
`ifdef DECODE_PERF_EN
   output logic [PC_W-1:0] ex_pc,
   output logic [15:0]     perf_stall,
   output logic [15:0]     perf_flush
`else
   output logic [PC_W-1:0] ex_pc
`endif
);

   localparam int unsigned CNT_W = (FLUSH_SLOTS > 1) ? $clog2(FLUSH_SLOTS + 1) : 1;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [3:0] CTRL_NOP  = 4'd0;
   localparam logic [3:0] CTRL_ALU  = 4'd1;
   localparam logic [3:0] CTRL_ADDI = 4'd2;
   localparam logic [3:0] CTRL_LW   = 4'd3;
   localparam logic [3:0] CTRL_SW   = 4'd4;

   typedef enum logic {StRun, StFlush} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             hold_q;
   logic [31:0]      hold_instr_q;
   logic [PC_W-1:0]  hold_pc_q;

   logic [31:0]      rf_q [32];

   logic [31:0]      cur_instr;
   logic [PC_W-1:0]  cur_pc;
   logic             cur_valid;
   logic [5:0]       op;
   logic [4:0]       rs, rt, rd;
   logic [31:0]      rs_val, rt_val, imm_ext;
   logic [3:0]       dec_ctrl;
   logic [4:0]       dec_rd;
   logic             uses_regs, is_beq, is_bne, is_j;
   logic             load_use, br_haz, stall, taken, issue, discard;
   logic [PC_W-1:0]  br_tgt;

   // A stalled instruction is replayed from the skid register, not from fetch.
   assign cur_instr = hold_q ? hold_instr_q : if_instr;
   assign cur_pc    = hold_q ? hold_pc_q : if_pc;
   assign cur_valid = hold_q | if_valid;

   assign op      = cur_instr[31:26];
   assign rs      = cur_instr[25:21];
   assign rt      = cur_instr[20:16];
   assign rd      = cur_instr[15:11];
   assign imm_ext = {{16{cur_instr[15]}}, cur_instr[15:0]};

   // Write-through bypass so a same-cycle writeback is visible to decode.
   always_comb begin
      rs_val = rf_q[rs];
      rt_val = rf_q[rt];
      if (wb_we && wb_addr == rs) rs_val = wb_data;
      if (wb_we && wb_addr == rt) rt_val = wb_data;
      if (rs == 5'd0) rs_val = 32'd0;
      if (rt == 5'd0) rt_val = 32'd0;
   end

   always_comb begin
      dec_ctrl  = CTRL_NOP;
      dec_rd    = 5'd0;
      uses_regs = 1'b0;
      is_beq    = 1'b0;
      is_bne    = 1'b0;
      is_j      = 1'b0;
      case (op)
         OP_R:    begin dec_ctrl = CTRL_ALU;  dec_rd = rd; uses_regs = 1'b1; end
         OP_ADDI: begin dec_ctrl = CTRL_ADDI; dec_rd = rt; uses_regs = 1'b1; end
         OP_LW:   begin dec_ctrl = CTRL_LW;   dec_rd = rt; uses_regs = 1'b1; end
         OP_SW:   begin dec_ctrl = CTRL_SW;   uses_regs = 1'b1; end
         OP_BEQ:  begin is_beq = 1'b1; uses_regs = 1'b1; end
         OP_BNE:  begin is_bne = 1'b1; uses_regs = 1'b1; end
         OP_J:    is_j = 1'b1;
         default: ;
      endcase
   end

   assign load_use = uses_regs && ex_valid && ex_ctrl == CTRL_LW && ex_rd != 5'd0 &&
                     (ex_rd == rs || ex_rd == rt);
   assign br_haz   = (is_beq || is_bne) &&
                     ((rs != 5'd0 && ((ex_valid && ex_rd == rs) || (mem_we && mem_rd == rs))) ||
                      (rt != 5'd0 && ((ex_valid && ex_rd == rt) || (mem_we && mem_rd == rt))));

   assign stall   = state_q == StRun && cur_valid && (load_use || br_haz);
   assign taken   = state_q == StRun && cur_valid && !stall &&
                    ((is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val) || is_j);
   assign issue   = state_q == StRun && cur_valid && !stall && dec_ctrl != CTRL_NOP;
   assign discard = state_q == StFlush && cur_valid;

   assign br_tgt       = cur_pc + PC_W'(cur_instr[6:0]);
   assign fetch_target = is_j ? PC_W'(cur_instr[6:0]) : br_tgt;
   assign fetch_sel    = !rst && taken;
   assign fetch_en     = rst || !stall;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StRun: begin
            if (taken && FLUSH_SLOTS != 0) begin
               state_d = StFlush;
               cnt_d   = CNT_W'(FLUSH_SLOTS);
            end
         end
         StFlush: begin
            if (discard) begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = StRun;
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         cnt_q   <= '0;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= stall;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_instr_q <= '0;
         hold_pc_q    <= '0;
      end else if (stall) begin
         hold_instr_q <= cur_instr;
         hold_pc_q    <= cur_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
      end else if (wb_we && wb_addr != 5'd0) begin
         rf_q[wb_addr] <= wb_data;
      end
   end

   // Bubbles (stall, flush, idle, branch/jump/unknown) clear the whole entry.
   always_ff @(posedge clk) begin
      if (rst || !issue) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= CTRL_NOP;
         ex_funct <= '0;
         ex_a     <= '0;
         ex_b     <= '0;
         ex_imm   <= '0;
         ex_rd    <= '0;
         ex_pc    <= '0;
      end else begin
         ex_valid <= 1'b1;
         ex_ctrl  <= dec_ctrl;
         ex_funct <= cur_instr[5:0];
         ex_a     <= rs_val;
         ex_b     <= rt_val;
         ex_imm   <= imm_ext;
         ex_rd    <= dec_rd;
         ex_pc    <= cur_pc;
      end
   end

`ifdef DECODE_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall <= '0;
         perf_flush <= '0;
      end else begin
         if (stall && perf_stall != 16'hFFFF) perf_stall <= perf_stall + 16'd1;
         if (discard && perf_flush != 16'hFFFF) perf_flush <= perf_flush + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Table-driven bench for decode_stage: per-cycle vectors with hand-computed fetch and ID/EX values.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_instr;
   logic [6:0]  if_pc;
   logic        if_valid;
   logic        fetch_sel;
   logic [6:0]  fetch_target;
   logic        fetch_en;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [4:0]  mem_rd;
   logic        mem_we;
   logic        ex_valid;
   logic [3:0]  ex_ctrl;
   logic [5:0]  ex_funct;
   logic [31:0] ex_a, ex_b, ex_imm;
   logic [4:0]  ex_rd;
   logic [6:0]  ex_pc;
`ifdef DECODE_PERF_EN
   logic [15:0] perf_stall, perf_flush;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   decode_stage #(.FLUSH_SLOTS(1), .PC_W(7)) dut (
      .clk(clk), .rst(rst),
      .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
      .fetch_sel(fetch_sel), .fetch_target(fetch_target), .fetch_en(fetch_en),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .mem_rd(mem_rd), .mem_we(mem_we),
      .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_funct(ex_funct),
      .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rd(ex_rd),
`ifdef DECODE_PERF_EN
      .ex_pc(ex_pc), .perf_stall(perf_stall), .perf_flush(perf_flush)
`else
      .ex_pc(ex_pc)
`endif
   );

   typedef struct {
      logic        rst;
      logic [31:0] instr;
      logic [6:0]  pc;
      logic        valid;
      logic        wb_we;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data;
      logic [4:0]  mem_rd;
      logic        mem_we;
      logic        e_sel;
      logic [6:0]  e_tgt;
      logic        e_en;
      logic        e_v;
      logic [3:0]  e_ctrl;
      logic        chk;
      logic [31:0] e_a, e_b, e_imm;
      logic [4:0]  e_rd;
      logic [6:0]  e_pc;
   } vec_t;

   vec_t tbl [64];
   int   n = 0;

   function automatic logic [31:0] r_op(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d);
      return {6'b000000, s, t, d, 5'd0, 6'h20};
   endfunction

   function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
      return {op, s, t, imm};
   endfunction

   function automatic logic [31:0] j_op(input logic [6:0] t);
      return {6'b000010, 19'd0, t};
   endfunction

   task automatic add(input logic [31:0] instr, input logic [6:0] pc, input logic valid,
                      input logic e_sel, input logic [6:0] e_tgt, input logic e_en,
                      input logic e_v, input logic [3:0] e_ctrl);
      tbl[n].rst = 1'b0;   tbl[n].instr = instr;  tbl[n].pc = pc;     tbl[n].valid = valid;
      tbl[n].wb_we = 1'b0; tbl[n].wb_addr = 5'd0; tbl[n].wb_data = 32'd0;
      tbl[n].mem_rd = 5'd0; tbl[n].mem_we = 1'b0;
      tbl[n].e_sel = e_sel; tbl[n].e_tgt = e_tgt; tbl[n].e_en = e_en;
      tbl[n].e_v = e_v;     tbl[n].e_ctrl = e_ctrl; tbl[n].chk = 1'b0;
      tbl[n].e_a = 32'd0; tbl[n].e_b = 32'd0; tbl[n].e_imm = 32'd0;
      tbl[n].e_rd = 5'd0; tbl[n].e_pc = 7'd0;
      n++;
   endtask

   task automatic data(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [4:0] rd, input logic [6:0] pc);
      tbl[n-1].chk = 1'b1; tbl[n-1].e_a = a; tbl[n-1].e_b = b; tbl[n-1].e_imm = imm;
      tbl[n-1].e_rd = rd;  tbl[n-1].e_pc = pc;
   endtask

   task automatic wb(input logic [4:0] addr, input logic [31:0] d);
      tbl[n-1].wb_we = 1'b1; tbl[n-1].wb_addr = addr; tbl[n-1].wb_data = d;
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] BNE  = 6'b000101;

   initial begin
      // Reset twice; second cycle has state defined and a J present that must not redirect.
      add(j_op(7'd127), 7'd0, 1, 0, 7'd0, 1, 0, 4'd0); tbl[n-1].rst = 1'b1;
      add(j_op(7'd127), 7'd0, 1, 0, 7'd0, 1, 0, 4'd0); tbl[n-1].rst = 1'b1;
      data(0, 0, 0, 0, 0);
      add(i_op(ADDI, 0, 1, 16'd5), 7'd1, 1, 0, 0, 1, 1, 4'd2); data(0, 0, 5, 1, 1);
      add(r_op(3, 0, 7), 7'd2, 1, 0, 0, 1, 1, 4'd1); wb(3, 32'hDEAD_BEEF);
      data(32'hDEAD_BEEF, 0, 32'h3820, 7, 2);
      add(r_op(0, 3, 8), 7'd3, 1, 0, 0, 1, 1, 4'd1); wb(0, 32'h1234_5678);
      data(0, 32'hDEAD_BEEF, 32'h4020, 8, 3);
      add(32'd0, 7'd0, 0, 0, 0, 1, 0, 4'd0); wb(5, 32'd7);
      add(32'd0, 7'd0, 0, 0, 0, 1, 0, 4'd0); wb(6, 32'd7);
      add(i_op(LW, 1, 2, 16'd4), 7'd4, 1, 0, 0, 1, 1, 4'd3); data(0, 0, 4, 2, 4);
      // Load-use: one stall, then the held ADD issues though fetch shows another word.
      add(r_op(2, 1, 4), 7'd5, 1, 0, 0, 0, 0, 4'd0);
      add(i_op(ADDI, 0, 9, 16'd99), 7'd6, 1, 0, 0, 1, 1, 4'd1); data(0, 0, 32'h2020, 4, 5);
      add(i_op(BEQ, 5, 6, 16'd3), 7'd10, 1, 1, 7'd13, 1, 0, 4'd0);
      add(i_op(ADDI, 0, 10, 16'd1), 7'd11, 1, 0, 0, 1, 0, 4'd0);
      add(i_op(ADDI, 0, 11, 16'd2), 7'd12, 1, 0, 0, 1, 1, 4'd2); data(0, 0, 2, 11, 12);
      add(i_op(BNE, 5, 6, 16'd3), 7'd13, 1, 0, 0, 1, 0, 4'd0);
      add(j_op(7'd127), 7'd14, 1, 1, 7'd127, 1, 0, 4'd0);
      add(32'd0, 7'd0, 0, 0, 0, 1, 0, 4'd0);
      add(i_op(ADDI, 0, 12, 16'd3), 7'd15, 1, 0, 0, 1, 0, 4'd0);
      add(i_op(BEQ, 5, 6, 16'd5), 7'd126, 1, 1, 7'd3, 1, 0, 4'd0);
      add(i_op(ADDI, 0, 12, 16'd3), 7'd127, 1, 0, 0, 1, 0, 4'd0);
      // Branch operand hazards: against ID/EX, then against MEM.
      add(i_op(ADDI, 0, 5, 16'd1), 7'd20, 1, 0, 0, 1, 1, 4'd2); data(0, 7, 1, 5, 20);
      add(i_op(BEQ, 5, 6, 16'd2), 7'd21, 1, 0, 0, 0, 0, 4'd0);
      add(i_op(BEQ, 5, 6, 16'd2), 7'd21, 1, 0, 0, 0, 0, 4'd0);
      tbl[n-1].mem_rd = 5'd5; tbl[n-1].mem_we = 1'b1;
      add(i_op(BEQ, 5, 6, 16'd2), 7'd21, 1, 1, 7'd23, 1, 0, 4'd0);
      add(i_op(ADDI, 0, 12, 16'd3), 7'd22, 1, 0, 0, 1, 0, 4'd0);
      add(i_op(ADDI, 0, 13, 16'd7), 7'd30, 1, 0, 0, 1, 1, 4'd2); data(0, 0, 7, 13, 30);
      add(i_op(6'b111111, 1, 2, 16'd3), 7'd31, 1, 0, 0, 1, 0, 4'd0);
      add(i_op(SW, 1, 3, 16'hFFFC), 7'd32, 1, 0, 0, 1, 1, 4'd4);
      data(0, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 0, 32);
      // Reset mid-stall drops the held ADD and clears the register file.
      add(i_op(LW, 1, 2, 16'd0), 7'd40, 1, 0, 0, 1, 1, 4'd3);
      add(r_op(2, 1, 4), 7'd41, 1, 0, 0, 0, 0, 4'd0);
      add(j_op(7'd127), 7'd42, 1, 0, 0, 1, 0, 4'd0); tbl[n-1].rst = 1'b1;
      data(0, 0, 0, 0, 0);
      add(32'd0, 7'd0, 0, 0, 0, 1, 0, 4'd0);
      add(i_op(ADDI, 5, 1, 16'd0), 7'd50, 1, 0, 0, 1, 1, 4'd2); data(0, 0, 0, 1, 50);
      // Two load-use stalls and one taken branch since the last reset.
      add(i_op(LW, 1, 2, 16'd0), 7'd60, 1, 0, 0, 1, 1, 4'd3);
      add(r_op(2, 1, 4), 7'd61, 1, 0, 0, 0, 0, 4'd0);
      add(r_op(2, 1, 4), 7'd61, 1, 0, 0, 1, 1, 4'd1);
      add(i_op(LW, 1, 2, 16'd0), 7'd62, 1, 0, 0, 1, 1, 4'd3);
      add(r_op(2, 1, 4), 7'd63, 1, 0, 0, 0, 0, 4'd0);
      add(r_op(2, 1, 4), 7'd63, 1, 0, 0, 1, 1, 4'd1);
      add(i_op(BEQ, 0, 0, 16'd1), 7'd64, 1, 1, 7'd65, 1, 0, 4'd0);
      add(i_op(ADDI, 0, 12, 16'd3), 7'd65, 1, 0, 0, 1, 0, 4'd0);

      for (int i = 0; i < n; i++) begin
         rst = tbl[i].rst; if_instr = tbl[i].instr; if_pc = tbl[i].pc; if_valid = tbl[i].valid;
         wb_we = tbl[i].wb_we; wb_addr = tbl[i].wb_addr; wb_data = tbl[i].wb_data;
         mem_rd = tbl[i].mem_rd; mem_we = tbl[i].mem_we;
         #1;
         check("fetch_sel", i, 32'(fetch_sel), 32'(tbl[i].e_sel));
         check("fetch_en", i, 32'(fetch_en), 32'(tbl[i].e_en));
         if (tbl[i].e_sel) check("fetch_target", i, 32'(fetch_target), 32'(tbl[i].e_tgt));
         @(posedge clk);
         #1;
         check("ex_valid", i, 32'(ex_valid), 32'(tbl[i].e_v));
         check("ex_ctrl", i, 32'(ex_ctrl), 32'(tbl[i].e_ctrl));
         if (tbl[i].chk) begin
            check("ex_a", i, ex_a, tbl[i].e_a);
            check("ex_b", i, ex_b, tbl[i].e_b);
            check("ex_imm", i, ex_imm, tbl[i].e_imm);
            check("ex_funct", i, 32'(ex_funct), 32'(tbl[i].e_imm[5:0]));
            check("ex_rd", i, 32'(ex_rd), 32'(tbl[i].e_rd));
            check("ex_pc", i, 32'(ex_pc), 32'(tbl[i].e_pc));
         end
      end

`ifdef DECODE_PERF_EN
      check("perf_stall", n, 32'(perf_stall), 32'd2);
      check("perf_flush", n, 32'(perf_flush), 32'd1);
      if_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("perf_stall_rst", n + 1, 32'(perf_stall), 32'd0);
      check("perf_flush_rst", n + 1, 32'(perf_flush), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
